turn_controller: RTL
====================

# turn_controller

Turn-sequencing controller for the tic-tac-toe datapath. It sits directly upstream of the board position registers. It accepts player and computer move requests, rejects moves to occupied or out-of-range cells, and issues one-cycle write enables. After each write it inspects the updated board fed back from the position registers and declares a win, a draw, or the next turn.

## Interface
Parameters: none (3x3 board fixed).

- clock  in  1  game clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; clears all state on the next clock edge
- play  in  1  player move request; rising-edge detected internally
- player_pos  in  4  player target cell; 1..9 valid, 0 and 10..15 illegal
- pc  in  1  computer move request; rising-edge detected internally
- computer_pos  in  4  computer target cell; 1..9 valid
- board  in  18  feedback from the position registers; board[2k+1:2k] is cell k+1; 00 empty, 01 player, 10 computer, 11 occupied (never counts toward a line)
- PL_en  out  9  player write enable, one-hot; bit k writes cell k+1
- PC_en  out  9  computer write enable, one-hot
- illegal_move  out  1  one-cycle pulse when a request is rejected
- turn  out  1  0 = player to move, 1 = computer to move
- winner  out  2  00 none, 01 player, 10 computer, 11 draw
- game_over  out  1  high in DONE

## Operation
- Edge detect: play_d and pc_d register the previous cycle's input. A request is accepted only when the input is 1 and its delayed copy is 0. Both delayed copies reset to 0.
- States: PLAYER (reset state), P_WRITE, P_CHECK, COMPUTER, C_WRITE, C_CHECK, DONE.
- PLAYER:
  - play edge with player_pos in 1..9 and that board cell = 00: register PL_en = one-hot, go to P_WRITE.
  - play edge otherwise: register illegal_move = 1 for one cycle, stay in PLAYER.
  - pc edges are ignored.
- P_WRITE: PL_en is high this cycle; clear it; go to P_CHECK.
- P_CHECK (board now updated):
  - Any of the 8 lines (rows 123/456/789, columns 147/258/369, diagonals 159/357) all 01: winner = 01, go to DONE.
  - Else all 9 cells non-zero: winner = 11, go to DONE.
  - Else go to COMPUTER.
- COMPUTER, C_WRITE, C_CHECK: mirror the player states using pc, computer_pos, PC_en, and pattern 10 (computer win = winner 10). A non-winning, non-full board returns to PLAYER.
- DONE: game_over = 1. All requests are ignored, no enables or illegal pulses are issued, and winner holds until reset.
- At most one enable bit across PL_en and PC_en is ever high in any cycle.
- Simultaneous play and pc edges: only the request belonging to the current state is considered. The other is discarded, not queued.
- An edge arriving in any WRITE or CHECK state is discarded. The input must fall and rise again to be accepted.
- turn = 1 in COMPUTER, C_WRITE and C_CHECK; 0 elsewhere.

## Timing
- Reset values: state PLAYER; PL_en, PC_en, illegal_move, turn, winner, game_over all 0; play_d and pc_d 0.
- Accepted request, counted from the cycle T in which the edge is sampled:
  - T+1: enable high for exactly one cycle.
  - T+2: board reflects the move; CHECK evaluates.
  - T+3: winner, game_over and turn show the result.
- Rejected request: illegal_move high in cycle T+1 only; state unchanged.
- A request held high through reset deassertion is accepted in the first cycle after reset.
- Reset asserted in any state, including mid-WRITE: the enables drop to 0 at the next edge. A write already captured by the position registers is cleared by their own reset.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset, then play edge with player_pos=5 on an empty board -> PL_en=9'h010 for one cycle at T+1, turn=1 at T+3, winner=00.
- Player at 5, then pc edge with computer_pos=5 -> illegal_move pulses once, PC_en stays 0, turn stays 1. Then computer_pos=1 -> PC_en=9'h001 for one cycle.
- player_pos=0 and player_pos=12 each -> one illegal_move pulse each, no enable, state PLAYER.
- Player moves 1, 2, 3 interleaved with computer moves 4, 5 -> after player cell 3, winner=01 and game_over=1 at T+3. Later play/pc edges produce no enable and no illegal pulse.
- Full-board sequence P1, C2, P3, C5, P4, C6, P8, C7, P9 -> winner=11 after the ninth move.
- play held high for 10 cycles -> exactly one PL_en pulse. play and pc rising together in PLAYER -> only PL_en fires. Reset during P_WRITE -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/turn_controller.sv
// Turn-sequencing controller for the tic-tac-toe datapath. Accepts edge-detected
// player/computer move requests, rejects illegal targets, pulses one-hot write enables
// to the position registers and judges the fed-back board after every write.
module turn_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        play,
    input  logic [3:0]  player_pos,
    input  logic        pc,
    input  logic [3:0]  computer_pos,
    input  logic [17:0] board,
    output logic [8:0]  PL_en,
    output logic [8:0]  PC_en,
    output logic        illegal_move,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over
);

    typedef enum logic [2:0] {
        StPlayer,
        StPWrite,
        StPCheck,
        StComputer,
        StCWrite,
        StCCheck,
        StDone
    } state_e;

    localparam logic [1:0] MarkPlayer   = 2'b01;
    localparam logic [1:0] MarkComputer = 2'b10;
    localparam logic [1:0] WinNone      = 2'b00;
    localparam logic [1:0] WinDraw      = 2'b11;

    state_e      state_q, state_d;
    logic        play_prev_q, pc_prev_q;
    logic [8:0]  pl_en_q, pl_en_d;
    logic [8:0]  pc_en_q, pc_en_d;
    logic        illegal_q, illegal_d;
    logic        turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic        game_over_q, game_over_d;

    logic        play_edge, pc_edge;
    logic [8:0]  player_cell, computer_cell;

    // True when all three cells of any row, column or diagonal hold the given mark.
    function automatic logic has_line(input logic [17:0] b, input logic [1:0] mark);
        logic [8:0] m;
        for (int k = 0; k < 9; k++) begin
            m[k] = (b[2*k +: 2] == mark);
        end
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    // One-hot of the target cell when pos is 1..9 and that cell is empty; zero otherwise.
    function automatic logic [8:0] free_cell(input logic [17:0] b, input logic [3:0] pos);
        logic [8:0] oh;
        oh = '0;
        for (int k = 0; k < 9; k++) begin
            if (pos == 4'(k + 1) && b[2*k +: 2] == 2'b00) begin
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic board_full(input logic [17:0] b);
        logic full;
        full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (b[2*k +: 2] == 2'b00) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

    assign play_edge     = play & ~play_prev_q;
    assign pc_edge       = pc & ~pc_prev_q;
    assign player_cell   = free_cell(board, player_pos);
    assign computer_cell = free_cell(board, computer_pos);

    // Next-state and next-output decode; enables and illegal pulses default to zero.
    always_comb begin
        state_d   = state_q;
        pl_en_d   = '0;
        pc_en_d   = '0;
        illegal_d = 1'b0;
        winner_d  = winner_q;
        unique case (state_q)
            StPlayer: begin
                if (play_edge) begin
                    if (|player_cell) begin
                        pl_en_d = player_cell;
                        state_d = StPWrite;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StPWrite: state_d = StPCheck;
            StPCheck: begin
                if (has_line(board, MarkPlayer)) begin
                    winner_d = MarkPlayer;
                    state_d  = StDone;
                end else if (board_full(board)) begin
                    winner_d = WinDraw;
                    state_d  = StDone;
                end else begin
                    state_d = StComputer;
                end
            end
            StComputer: begin
                if (pc_edge) begin
                    if (|computer_cell) begin
                        pc_en_d = computer_cell;
                        state_d = StCWrite;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StCWrite: state_d = StCCheck;
            StCCheck: begin
                if (has_line(board, MarkComputer)) begin
                    winner_d = MarkComputer;
                    state_d  = StDone;
                end else if (board_full(board)) begin
                    winner_d = WinDraw;
                    state_d  = StDone;
                end else begin
                    state_d = StPlayer;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StPlayer;
        endcase
        // Status outputs are registered copies of what the next state implies.
        turn_d      = (state_d == StComputer) || (state_d == StCWrite) || (state_d == StCCheck);
        game_over_d = (state_d == StDone);
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StPlayer;
            play_prev_q <= 1'b0;
            pc_prev_q   <= 1'b0;
            pl_en_q     <= '0;
            pc_en_q     <= '0;
            illegal_q   <= 1'b0;
            turn_q      <= 1'b0;
            winner_q    <= WinNone;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            play_prev_q <= play;
            pc_prev_q   <= pc;
            pl_en_q     <= pl_en_d;
            pc_en_q     <= pc_en_d;
            illegal_q   <= illegal_d;
            turn_q      <= turn_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
        end
    end

    assign PL_en        = pl_en_q;
    assign PC_en        = pc_en_q;
    assign illegal_move = illegal_q;
    assign turn         = turn_q;
    assign winner       = winner_q;
    assign game_over    = game_over_q;

endmodule
